// File: rtl/audio_codec_serdes.sv
`default_nettype none
// ============================================================================
// Module   : audio_codec_serdes
// Purpose  : I2S slave bridge between CLOCK_50 fabric logic and an audio codec
//            that is bit-clock master. It deserializes ADC words into a stereo
//            capture FIFO and serializes a stereo playback FIFO onto
//            AUD_DACDAT.
// Option   : AUDIO_CODEC_UNDERRUN_HOLD_EN - when defined, a playback underrun
//            repeats the last transmitted pair. When undefined, an underrun
//            sends zeros.
// Revision : 1.0 - initial release
// ============================================================================
module audio_codec_serdes #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 128
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] writedata_left,
    input  logic [DATA_WIDTH-1:0] writedata_right,
    input  logic                  AUD_ADCDAT,
    input  logic                  AUD_BCLK,
    input  logic                  AUD_ADCLRCK,
    input  logic                  AUD_DACLRCK,
    output logic                  read_ready,
    output logic                  write_ready,
    output logic [DATA_WIDTH-1:0] readdata_left,
    output logic [DATA_WIDTH-1:0] readdata_right,
    output logic                  AUD_DACDAT
);
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_WIDTH - 1);

    // ---------------- input synchronizers and edge detection ----------------
    // Bit order in the sync vectors: {ADCDAT, DACLRCK, ADCLRCK, BCLK}
    logic [3:0] sync_s1;
    logic [3:0] sync_s2;
    logic [2:0] edge_prev;

    // Two-flop synchronizers of equal depth keep data aligned with BCLK edges
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync_s1   <= '0;
            sync_s2   <= '0;
            edge_prev <= '0;
        end else begin
            sync_s1   <= {AUD_ADCDAT, AUD_DACLRCK, AUD_ADCLRCK, AUD_BCLK};
            sync_s2   <= sync_s1;
            edge_prev <= sync_s2[2:0];
        end
    end

    logic bclk_rise, bclk_fall, adclrck_rise, adclrck_fall;
    logic daclrck_rise, daclrck_fall, adcdat_bit;
    assign bclk_rise    =  sync_s2[0] & ~edge_prev[0];
    assign bclk_fall    = ~sync_s2[0] &  edge_prev[0];
    assign adclrck_rise =  sync_s2[1] & ~edge_prev[1];
    assign adclrck_fall = ~sync_s2[1] &  edge_prev[1];
    assign daclrck_rise =  sync_s2[2] & ~edge_prev[2];
    assign daclrck_fall = ~sync_s2[2] &  edge_prev[2];
    assign adcdat_bit   =  sync_s2[3];

    // ---------------- capture FIFO ----------------
    logic [2*DATA_WIDTH-1:0] cap_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]       cap_wr_ptr, cap_rd_ptr;
    logic [CNT_W-1:0]        cap_count, cap_count_next;
    logic                    cap_push, cap_pop, adc_push_req;
    logic [DATA_WIDTH-1:0]   adc_left, adc_right;

    assign cap_pop  = read && read_ready;
    // A pop in the same cycle frees the slot, so a push at full is still legal
    assign cap_push = adc_push_req && ((cap_count != FULL_COUNT) || cap_pop);

    // Next occupancy of the capture FIFO
    always_comb begin
        cap_count_next = cap_count;
        if (cap_push && !cap_pop)
            cap_count_next = cap_count + CNT_W'(1);
        else if (!cap_push && cap_pop)
            cap_count_next = cap_count - CNT_W'(1);
    end

    // Capture storage array
    always_ff @(posedge CLOCK_50) begin
        if (cap_push)
            cap_mem[cap_wr_ptr] <= {adc_left, adc_right};
    end

    // Capture pointers, occupancy and the registered non-empty flag
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cap_wr_ptr <= '0;
            cap_rd_ptr <= '0;
            cap_count  <= '0;
            read_ready <= 1'b0;
        end else begin
            if (cap_push) cap_wr_ptr <= cap_wr_ptr + ADDR_W'(1);
            if (cap_pop)  cap_rd_ptr <= cap_rd_ptr + ADDR_W'(1);
            cap_count  <= cap_count_next;
            read_ready <= (cap_count_next != '0);
        end
    end

    // Show-ahead head of the capture FIFO, zero while empty
    assign readdata_left  = read_ready ? cap_mem[cap_rd_ptr][2*DATA_WIDTH-1:DATA_WIDTH] : '0;
    assign readdata_right = read_ready ? cap_mem[cap_rd_ptr][DATA_WIDTH-1:0] : '0;

    // ---------------- playback FIFO ----------------
    logic [2*DATA_WIDTH-1:0] pb_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]       pb_wr_ptr, pb_rd_ptr;
    logic [CNT_W-1:0]        pb_count, pb_count_next;
    logic                    pb_push, pb_pop, pb_empty;

    assign pb_empty = (pb_count == '0);
    assign pb_push  = write && write_ready;
    // The DAC engine pops once per frame; on an empty FIFO a coincident push
    // is consumed as underrun so occupancy stays unchanged
    assign pb_pop   = daclrck_fall && (!pb_empty || pb_push);

    // Next occupancy of the playback FIFO
    always_comb begin
        pb_count_next = pb_count;
        if (pb_push && !pb_pop)
            pb_count_next = pb_count + CNT_W'(1);
        else if (!pb_push && pb_pop)
            pb_count_next = pb_count - CNT_W'(1);
    end

    // Playback storage array
    always_ff @(posedge CLOCK_50) begin
        if (pb_push)
            pb_mem[pb_wr_ptr] <= {writedata_left, writedata_right};
    end

    // Playback pointers, occupancy and the registered not-full flag
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            pb_wr_ptr   <= '0;
            pb_rd_ptr   <= '0;
            pb_count    <= '0;
            write_ready <= 1'b0;
        end else begin
            if (pb_push) pb_wr_ptr <= pb_wr_ptr + ADDR_W'(1);
            if (pb_pop)  pb_rd_ptr <= pb_rd_ptr + ADDR_W'(1);
            pb_count    <= pb_count_next;
            write_ready <= (pb_count_next != FULL_COUNT);
        end
    end

    // ---------------- ADC engine ----------------
    typedef enum logic [1:0] {
        ADC_WAIT_FRAME = 2'd0,
        ADC_SKIP       = 2'd1,
        ADC_SHIFT      = 2'd2,
        ADC_IDLE_BITS  = 2'd3
    } adc_state_t;

    adc_state_t       adc_state;
    logic             adc_right_word;
    logic [BIT_W-1:0] adc_bit_cnt;

    // Frame sequencer: left word on ADCLRCK fall, right word on rise, push at end
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            adc_state      <= ADC_WAIT_FRAME;
            adc_right_word <= 1'b0;
            adc_bit_cnt    <= '0;
            adc_left       <= '0;
            adc_right      <= '0;
            adc_push_req   <= 1'b0;
        end else begin
            adc_push_req <= 1'b0;
            if (adclrck_fall) begin
                adc_state      <= ADC_SKIP;
                adc_right_word <= 1'b0;
                adc_bit_cnt    <= '0;
            end else begin
                case (adc_state)
                    ADC_WAIT_FRAME: begin
                    end
                    ADC_SKIP: begin
                        if (bclk_rise)
                            adc_state <= ADC_SHIFT;
                    end
                    ADC_SHIFT: begin
                        if (adclrck_rise) begin
                            // Word select moved before a full word arrived
                            adc_state <= ADC_WAIT_FRAME;
                        end else if (bclk_rise) begin
                            if (adc_right_word)
                                adc_right <= {adc_right[DATA_WIDTH-2:0], adcdat_bit};
                            else
                                adc_left  <= {adc_left[DATA_WIDTH-2:0], adcdat_bit};
                            adc_bit_cnt <= adc_bit_cnt + BIT_W'(1);
                            if (adc_bit_cnt == LAST_BIT) begin
                                if (adc_right_word) begin
                                    adc_push_req <= 1'b1;
                                    adc_state    <= ADC_WAIT_FRAME;
                                end else begin
                                    adc_state    <= ADC_IDLE_BITS;
                                end
                            end
                        end
                    end
                    ADC_IDLE_BITS: begin
                        if (adclrck_rise && !adc_right_word) begin
                            adc_state      <= ADC_SKIP;
                            adc_right_word <= 1'b1;
                            adc_bit_cnt    <= '0;
                        end
                    end
                    default: adc_state <= ADC_WAIT_FRAME;
                endcase
            end
        end
    end

    // ---------------- DAC engine ----------------
    typedef enum logic [1:0] {
        DAC_WAIT_FRAME = 2'd0,
        DAC_SHIFT      = 2'd1,
        DAC_IDLE_BITS  = 2'd2
    } dac_state_t;

    dac_state_t              dac_state;
    logic [DATA_WIDTH-1:0]   dac_word, dac_right_hold;
    logic [BIT_W-1:0]        dac_bit_cnt;
    logic [2*DATA_WIDTH-1:0] dac_load_pair, dac_underrun_pair;

`ifdef AUDIO_CODEC_UNDERRUN_HOLD_EN
    logic [2*DATA_WIDTH-1:0] dac_last_pair;

    // Remember the pair most recently loaded for transmission
    always_ff @(posedge CLOCK_50) begin
        if (reset)
            dac_last_pair <= '0;
        else if (daclrck_fall)
            dac_last_pair <= dac_load_pair;
    end

    assign dac_underrun_pair = dac_last_pair;
`else
    assign dac_underrun_pair = '0;
`endif

    assign dac_load_pair = pb_empty ? dac_underrun_pair : pb_mem[pb_rd_ptr];

    // Serializer: load on DACLRCK fall, switch to right on rise, shift on BCLK fall
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            dac_state      <= DAC_WAIT_FRAME;
            dac_word       <= '0;
            dac_right_hold <= '0;
            dac_bit_cnt    <= '0;
            AUD_DACDAT     <= 1'b0;
        end else if (daclrck_fall) begin
            dac_state      <= DAC_SHIFT;
            dac_word       <= dac_load_pair[2*DATA_WIDTH-1:DATA_WIDTH];
            dac_right_hold <= dac_load_pair[DATA_WIDTH-1:0];
            dac_bit_cnt    <= '0;
            if (bclk_fall) AUD_DACDAT <= 1'b0;
        end else if (daclrck_rise && (dac_state != DAC_WAIT_FRAME)) begin
            dac_state   <= DAC_SHIFT;
            dac_word    <= dac_right_hold;
            dac_bit_cnt <= '0;
            if (bclk_fall) AUD_DACDAT <= 1'b0;
        end else if (bclk_fall) begin
            case (dac_state)
                DAC_SHIFT: begin
                    AUD_DACDAT  <= dac_word[DATA_WIDTH-1];
                    dac_word    <= dac_word << 1;
                    dac_bit_cnt <= dac_bit_cnt + BIT_W'(1);
                    if (dac_bit_cnt == LAST_BIT)
                        dac_state <= DAC_IDLE_BITS;
                end
                default: AUD_DACDAT <= 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_audio_codec_serdes.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_codec_serdes
// Purpose  : Directed bench for audio_codec_serdes with an I2S codec model
//            (BCLK = CLOCK_50/16, 64 BCLK per frame).
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_codec_serdes;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          reset;
    logic          read_drv, write_drv, tie_write;
    logic          read, write;
    logic [DW-1:0] wl, wr;
    logic          adcdat, bclk, adclrck, daclrck;
    logic          read_ready, write_ready, dacdat;
    logic [DW-1:0] rdl, rdr;

    int checks   = 0;
    int failures = 0;

    always #10 clk = ~clk;

    assign read  = read_drv;
    assign write = tie_write ? write_ready : write_drv;

    audio_codec_serdes #(.DATA_WIDTH(DW), .FIFO_DEPTH(128)) dut (
        .CLOCK_50        (clk),
        .reset           (reset),
        .read            (read),
        .write           (write),
        .writedata_left  (wl),
        .writedata_right (wr),
        .AUD_ADCDAT      (adcdat),
        .AUD_BCLK        (bclk),
        .AUD_ADCLRCK     (adclrck),
        .AUD_DACLRCK     (daclrck),
        .read_ready      (read_ready),
        .write_ready     (write_ready),
        .readdata_left   (rdl),
        .readdata_right  (rdr),
        .AUD_DACDAT      (dacdat)
    );

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One I2S frame: word select and data change on BCLK fall, sampled on rise.
    // Bit for rise i (1..DW) is word[DW-i]; rise 0 is the one-bit delay slot.
    task automatic run_frame(input logic [DW-1:0] adc_l, input logic [DW-1:0] adc_r,
                             input bit abort,
                             output logic [DW-1:0] dac_l, output logic [DW-1:0] dac_r);
        logic [DW-1:0] word;
        logic [DW-1:0] got;
        dac_l = '0;
        dac_r = '0;
        for (int ch = 0; ch < 2; ch++) begin
            word = (ch == 0) ? adc_l : adc_r;
            got  = '0;
            for (int i = 0; i < 32; i++) begin
                @(negedge clk);
                bclk = 1'b0;
                if (i == 0) begin
                    adclrck = ch[0];
                    daclrck = ch[0];
                end
                adcdat = (i >= 1 && i <= DW) ? word[DW-i] : 1'b0;
                if (abort && ch == 0 && i == 11) begin
                    reset = 1'b1;
                    repeat (2) @(negedge clk);
                    reset = 1'b0;
                end
                repeat (8) @(negedge clk);
                bclk = 1'b1;
                if (i >= 1 && i <= DW) got[DW-i] = dacdat;
                repeat (7) @(negedge clk);
            end
            if (ch == 0) dac_l = got;
            else         dac_r = got;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] dl, dr;
        logic [DW-1:0] hold_l, hold_r;
        int pushes;

        reset = 1'b1; read_drv = 1'b0; write_drv = 1'b0; tie_write = 1'b0;
        wl = '0; wr = '0;
        bclk = 1'b1; adclrck = 1'b1; daclrck = 1'b1; adcdat = 1'b0;

        // Reset held two cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_read_ready",  48'(read_ready),  48'd0);
        check("rst_write_ready", 48'(write_ready), 48'd0);
        check("rst_dacdat",      48'(dacdat),      48'd0);
        check("rst_readdata_l",  48'(rdl),         48'd0);
        check("rst_readdata_r",  48'(rdr),         48'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_write_ready", 48'(write_ready), 48'd1);
        check("post_rst_read_ready",  48'(read_ready),  48'd0);
        check("post_rst_dacdat",      48'(dacdat),      48'd0);

        // Playback 40000 / -40000, capture A5A5A5 / 5A5A5A
        write_drv = 1'b1; wl = 24'd40000; wr = -24'sd40000;
        @(negedge clk);
        write_drv = 1'b0;
        check("one_pair_write_ready", 48'(write_ready), 48'd1);
        check("cap_empty_before",     48'(read_ready),  48'd0);
        run_frame(24'hA5A5A5, 24'h5A5A5A, 1'b0, dl, dr);
        check("dac_left_40000",   48'(dl),  48'h009C40);
        check("dac_right_m40000", 48'(dr),  48'hFF63C0);
        check("cap_ready",        48'(read_ready), 48'd1);
        check("cap_left_a5",      48'(rdl), 48'hA5A5A5);
        check("cap_right_5a",     48'(rdr), 48'h5A5A5A);
        read_drv = 1'b1;
        @(negedge clk);
        read_drv = 1'b0;
        check("cap_ready_after_pop", 48'(read_ready), 48'd0);
        check("cap_left_after_pop",  48'(rdl),        48'd0);

        // Fill playback FIFO with write tied to write_ready
        tie_write = 1'b1;
        pushes = 0;
        for (int cyc = 0; cyc < 300 && write_ready; cyc++) begin
            wl = 24'h100000 + pushes[DW-1:0];
            wr = 24'h200000 + pushes[DW-1:0];
            @(negedge clk);
            pushes++;
        end
        tie_write = 1'b0;
        check("fill_push_count",  48'(pushes),      48'd128);
        check("full_write_ready", 48'(write_ready), 48'd0);
        write_drv = 1'b1; wl = 24'h999999; wr = 24'h999999;
        @(negedge clk);
        write_drv = 1'b0;
        check("write_when_full_ignored", 48'(write_ready), 48'd0);
        run_frame(24'h123456, 24'hFEDCBA, 1'b0, dl, dr);
        check("full_first_pop_left",  48'(dl),          48'h100000);
        check("full_first_pop_right", 48'(dr),          48'h200000);
        check("write_ready_returns",  48'(write_ready), 48'd1);
        check("cap2_ready",           48'(read_ready),  48'd1);
        check("cap2_left",            48'(rdl),         48'h123456);
        check("cap2_right",           48'(rdr),         48'hFEDCBA);
        read_drv = 1'b1;
        @(negedge clk);
        read_drv = 1'b0;
        check("cap2_ready_after_pop", 48'(read_ready), 48'd0);

        // Reset in the middle of the left ADC word
        run_frame(24'hFFFFFF, 24'hFFFFFF, 1'b1, dl, dr);
        check("abort_no_push",        48'(read_ready),  48'd0);
        check("abort_pb_flushed_rdy", 48'(write_ready), 48'd1);
        run_frame(24'h0F0F0F, 24'hF0F0F0, 1'b0, dl, dr);
        check("post_abort_dac_left",  48'(dl), 48'd0);
        check("post_abort_dac_right", 48'(dr), 48'd0);
        check("resume_cap_ready",     48'(read_ready), 48'd1);
        check("resume_cap_left",      48'(rdl), 48'h0F0F0F);
        check("resume_cap_right",     48'(rdr), 48'hF0F0F0);
        read_drv = 1'b1;
        @(negedge clk);
        read_drv = 1'b0;

        // One written pair, then three underrun frames
        write_drv = 1'b1; wl = 24'h7FFFFF; wr = 24'h800001;
        @(negedge clk);
        write_drv = 1'b0;
        run_frame(24'h000001, 24'h800000, 1'b0, dl, dr);
        check("last_pair_left",  48'(dl), 48'h7FFFFF);
        check("last_pair_right", 48'(dr), 48'h800001);
`ifdef AUDIO_CODEC_UNDERRUN_HOLD_EN
        hold_l = 24'h7FFFFF;
        hold_r = 24'h800001;
`else
        hold_l = 24'h000000;
        hold_r = 24'h000000;
`endif
        for (int f = 0; f < 3; f++) begin
            run_frame(24'h333333, 24'hCCCCCC, 1'b0, dl, dr);
            check("underrun_left",  48'(dl), 48'(hold_l));
            check("underrun_right", 48'(dr), 48'(hold_r));
        end
        check("underrun_cap_head_left", 48'(rdl), 48'h000001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/audio_codec_serdes.md
Name: audio_codec_serdes

Overview:
- Streaming bridge between a fabric core on CLOCK_50 and an external audio codec running as I2S master (codec drives BCLK, ADCLRCK, DACLRCK).
- Deserializes ADC audio into a stereo capture FIFO and serializes a stereo playback FIFO onto AUD_DACDAT.
- Sits under the audio top level, beside the codec config and clock-generator blocks.
- Tone generators push samples with a ready/valid-style handshake.

Parameters:
- DATA_WIDTH, 24: bits per channel sample, two's complement, MSB first on the serial line.
- FIFO_DEPTH, 128: stereo sample pairs per direction; power of two, minimum 4.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz; all logic is synchronous to it.
- reset  in  1  synchronous, active-high.
- read  in  1  pop one capture pair; honoured only when read_ready is high.
- write  in  1  push one playback pair; honoured only when write_ready is high.
- writedata_left  in  DATA_WIDTH  playback left sample.
- writedata_right  in  DATA_WIDTH  playback right sample.
- AUD_ADCDAT  in  1  serial ADC data from the codec.
- AUD_BCLK  in  1  codec bit clock, at most 1/8 of CLOCK_50.
- AUD_ADCLRCK  in  1  ADC word select; low = left, high = right.
- AUD_DACLRCK  in  1  DAC word select; low = left, high = right.
- read_ready  out  1  capture FIFO non-empty.
- write_ready  out  1  playback FIFO not full.
- readdata_left  out  DATA_WIDTH  head-of-FIFO capture left sample (show-ahead).
- readdata_right  out  DATA_WIDTH  head-of-FIFO capture right sample.
- AUD_DACDAT  out  1  serial DAC data to the codec.

Behaviour:
- Interface stated as fixed: one clock, CLOCK_50; reset is synchronous and active-high, named reset.
- Input synchronization:
  - AUD_BCLK, AUD_ADCLRCK, AUD_DACLRCK and AUD_ADCDAT each pass through a 2-flop synchronizer of identical depth.
  - Edges are detected from the synchronized copies, one CLOCK_50 cycle each.
- Reset values:
  - Both FIFOs flushed.
  - read_ready=0, write_ready=0, readdata_left/right=0, AUD_DACDAT=0.
  - Both serial engines go to WAIT_FRAME.
  - write_ready rises on the first cycle after reset deasserts.
  - Reset asserted mid-frame aborts the frame in progress; no partial sample is pushed or kept.
- Handshake:
  - Push occurs when write && write_ready; pop occurs when read && read_ready. Each takes one cycle.
  - write while full is ignored, with no state change. read while empty is ignored.
  - Flags and pointers update on the clock edge after the accepted transfer.
  - readdata shows the next pair on the cycle after a pop, or 0 when empty.
  - Tying read=read_ready and write=write_ready must work; the bench does this.
- ADC engine, states WAIT_FRAME -> SKIP -> SHIFT -> IDLE_BITS:
  - WAIT_FRAME: wait for an ADCLRCK falling edge (left word start) -> SKIP.
  - SKIP: ignore the first BCLK rising edge (I2S one-bit delay) -> SHIFT.
  - SHIFT: on each subsequent BCLK rising edge, shift in the synchronized ADCDAT bit, MSB first, for DATA_WIDTH bits -> IDLE_BITS.
  - IDLE_BITS: extra bits are ignored. An ADCLRCK rising edge -> SKIP for the right word.
  - After the right word completes, the pair is pushed the next cycle, then -> WAIT_FRAME.
  - If the capture FIFO is full, the pair is dropped. A push coincident with a user pop in the same cycle is legal, including at the full boundary.
- DAC engine:
  - On a DACLRCK falling edge, pop one pair from the playback FIFO into the left and right shift registers.
  - If the FIFO is empty (underrun), load zeros.
  - On each BCLK falling edge strictly after a DACLRCK edge, drive the next bit, MSB first, for DATA_WIDTH bits; then drive 0 until the next DACLRCK edge.
  - A DACLRCK rising edge restarts the bit count on the right register.
  - AUD_DACDAT is registered and changes only in the cycle after a detected BCLK falling edge.
  - A DACLRCK edge arriving mid-word truncates that word.
- FIFOs:
  - Synchronous, registered pointers, one pair (2*DATA_WIDTH) per entry.
  - Simultaneous push and pop keeps the count unchanged, including when empty (writer push plus engine pop).
  - The empty FIFO case behaves as an underrun and yields zeros.

Optional Feature:
- AUDIO_CODEC_UNDERRUN_HOLD_EN.
- Defined: on playback underrun, the DAC engine re-sends the last transmitted pair instead of zeros; after reset, the "last pair" is 0.
- Undefined: underrun sends zeros.

Test Plan:
- Reset held 2 cycles, then released -> read_ready=0, AUD_DACDAT=0, write_ready=1 on the first post-reset cycle.
- Write pair L=24'd40000, R=-24'sd40000, with a codec model at BCLK=3.125 MHz and 64 BCLK per frame -> next frame's DACDAT carries 0x009C40 on left and 0xFF63C0 on right, MSB first starting at the 2nd BCLK rise.
- Codec model sends ADC L=0xA5A5A5, R=0x5A5A5A -> read_ready rises within one frame; readdata_left=0xA5A5A5, readdata_right=0x5A5A5A; read pops and read_ready falls.
- Push 128 pairs with no frames running -> write_ready=0 after the 128th; a 129th write is ignored; the first frame pops one pair and write_ready returns to 1.
- Run 3 frames with no writes -> DACDAT is all zeros; with AUDIO_CODEC_UNDERRUN_HOLD_EN, the last written pair repeats instead.
- Assert reset at ADC bit 10 of the left word -> no pair is pushed; capture resumes cleanly at the next full frame.
